cmplt_pipe: RTL and testbench

- Registered dual-mode (signed/unsigned) less-than comparator.
- Reports whether operand a is strictly less than operand b. A per-sample is_signed control selects two's-complement or unsigned interpretation.
- Used in ALU/datapath stages that need a compare flag with a valid qualifier and one-cycle registered timing.

---
 rtl/cmplt_pipe.sv | 45 ++++
 tb/tb_cmplt_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cmplt_pipe.sv
// Registered signed/unsigned less-than comparator with equality flag.
// One-cycle latency, full throughput, outputs driven only from flops.
module cmplt_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             out,
  output logic             eq
);

  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;
  logic             lt;

  // Flipping the MSB maps two's-complement order onto unsigned order,
  // so one magnitude comparator serves both modes.
  always_comb begin
    a_cmp = a;
    b_cmp = b;
    a_cmp[WIDTH-1] = a[WIDTH-1] ^ is_signed;
    b_cmp[WIDTH-1] = b[WIDTH-1] ^ is_signed;
    lt = (a_cmp < b_cmp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= 1'b0;
      eq        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= lt;
        eq  <= (a == b);
      end
    end
  end

endmodule

// File: tb/tb_cmplt_pipe.sv
// Self-checking bench for cmplt_pipe: directed literal vectors, reset and
// bubble cases, and a random run against an arithmetic reference model.
module tb_cmplt_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid, out, eq;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic m_valid = 1'b0, m_out = 1'b0, m_eq = 1'b0;

  cmplt_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .is_signed(is_signed),
    .a(a), .b(b), .out_valid(out_valid), .out(out), .eq(eq)
  );

  always #5 clk = ~clk;

  // Reference: interpret operands as integers and compare numerically.
  function automatic logic ref_lt(logic s, logic [W-1:0] x, logic [W-1:0] y);
    longint vx, vy;
    vx = longint'(x);
    vy = longint'(y);
    if (s && x[W-1]) vx = vx - (longint'(1) << W);
    if (s && y[W-1]) vy = vy - (longint'(1) << W);
    return vx < vy;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_out = 1'b0; m_eq = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_out = ref_lt(is_signed, a, b);
        m_eq  = (a == b);
      end
    end
  end

  task automatic chk(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", out_valid, m_valid);
      chk("model_out", out, m_out);
      chk("model_eq", eq, m_eq);
    end
  end

  // Apply one sample; check DUT and model against hand-computed values after capture.
  task automatic lit(logic s, logic [W-1:0] x, logic [W-1:0] y, logic eo, logic ee);
    in_valid = 1'b1; is_signed = s; a = x; b = y;
    @(posedge clk); #1;
    chk($sformatf("lit_valid s=%0d a=%h b=%h", s, x, y), out_valid, 1'b1);
    chk($sformatf("lit_out s=%0d a=%h b=%h", s, x, y), out, eo);
    chk($sformatf("lit_eq s=%0d a=%h b=%h", s, x, y), eq, ee);
    chk($sformatf("lit_model_out s=%0d a=%h b=%h", s, x, y), m_out, eo);
  endtask

  initial begin
    #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_out", out, 1'b0);
    chk("reset_eq", eq, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Mode split, alternating is_signed back-to-back
    lit(0, 16'hFFFF, 16'h0001, 0, 0);
    lit(1, 16'hFFFF, 16'h0001, 1, 0);
    lit(0, 16'h0002, 16'hFFFF, 1, 0);
    lit(1, 16'h0002, 16'hFFFF, 0, 0);
    // Same-sign ordering
    lit(0, 16'h0002, 16'h0001, 0, 0);
    lit(1, 16'h0002, 16'h0001, 0, 0);
    lit(0, 16'h0001, 16'h0002, 1, 0);
    lit(1, 16'h0001, 16'h0002, 1, 0);
    lit(0, 16'hFFFE, 16'hFFFF, 1, 0);
    lit(1, 16'hFFFE, 16'hFFFF, 1, 0);
    lit(0, 16'hFFFF, 16'hFFFE, 0, 0);
    lit(1, 16'hFFFF, 16'hFFFE, 0, 0);
    // Equality
    lit(0, 16'h0000, 16'h0000, 0, 1);
    lit(1, 16'h0000, 16'h0000, 0, 1);
    lit(0, 16'hFFFF, 16'hFFFF, 0, 1);
    lit(1, 16'hFFFF, 16'hFFFF, 0, 1);
    // Extremes
    lit(1, 16'h8000, 16'h7FFF, 1, 0);
    lit(0, 16'h8000, 16'h7FFF, 0, 0);
    lit(1, 16'h7FFF, 16'h8000, 0, 0);
    lit(0, 16'h7FFF, 16'h8000, 1, 0);
    lit(1, 16'hFFFF, 16'h0000, 1, 0);
    lit(0, 16'hFFFF, 16'h0000, 0, 0);

    // Bubble: out_valid drops, out/eq hold the last result (a=b -> out=0, eq=1)
    lit(0, 16'h1234, 16'h1234, 0, 1);
    in_valid = 1'b0; is_signed = 1'b0; a = 16'h0001; b = 16'h0002;
    @(posedge clk); #1;
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_out_hold", out, 1'b0);
    chk("bubble_eq_hold", eq, 1'b1);

    // Mid-cycle asynchronous reset with a valid sample pending
    lit(1, 16'h8000, 16'h0001, 1, 0);
    in_valid = 1'b1; is_signed = 1'b0; a = 16'h0005; b = 16'h0005;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_out", out, 1'b0);
    chk("async_rst_eq", eq, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", out_valid, 1'b0);
    chk("rst_hold_eq", eq, 1'b0);
    rst = 1'b0; a = 16'h0001; b = 16'h0002;
    #1;
    chk("post_release_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("first_after_rst_valid", out_valid, 1'b1);
    chk("first_after_rst_out", out, 1'b1);
    chk("first_after_rst_eq", eq, 1'b0);

    // Random regression
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 9) != 0);
      is_signed = $urandom_range(0, 1);
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0: b = a;
        1: b = a ^ {1'b1, {(W-1){1'b0}}};
        2: b = a + 1'b1;
        default: b = W'($urandom);
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
